// File: rtl/serial_tx_fifo_pkg.sv
// Shared types for the serial transmit FIFO: byte type, output-slot state and pointer sizing.
package Vermicom_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_state_t;

    // Pointer width for an array of the given entry count; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_fifo_if.sv
// Producer/transmitter handshake bundle for serial_tx_fifo.
// Carries threshold/irq only when SERIAL_TX_FIFO_LOW_WATER_IRQ_EN is defined.
interface serial_tx_fifo_if
    import Vermicom_pkg::*;
#(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          clear;
    logic          wr_valid;
    byte_t         wr_data;
    logic          wr_ready;
    logic          rd_valid;
    byte_t         rd_data;
    logic          rd_ready;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef SERIAL_TX_FIFO_LOW_WATER_IRQ_EN
    logic [LW-1:0] threshold;
    logic          irq;

    modport master (
        output clear, wr_valid, wr_data, rd_ready, threshold,
        input  wr_ready, rd_valid, rd_data, level, overflow, irq
    );
    modport slave (
        input  clear, wr_valid, wr_data, rd_ready, threshold,
        output wr_ready, rd_valid, rd_data, level, overflow, irq
    );
`else
    modport master (
        output clear, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, level, overflow
    );
    modport slave (
        input  clear, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, level, overflow
    );
`endif
endinterface

// File: rtl/serial_tx_fifo_ram.sv
// Byte storage behind the output slot: synchronous write, asynchronous read, no reset.
module serial_tx_fifo_ram
    import Vermicom_pkg::*;
#(
    parameter int unsigned ENTRIES = 15,
    parameter int unsigned AW      = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);
    byte_t mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/serial_tx_fifo.sv
// Byte FIFO with a registered first-word-fall-through output slot in front of a DEPTH-1 array.
// Optional low-water interrupt selected by SERIAL_TX_FIFO_LOW_WATER_IRQ_EN.
module serial_tx_fifo
    import Vermicom_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    serial_tx_fifo_if.slave  bus
);
    localparam int unsigned LW      = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRIES = DEPTH - 1;
    localparam int unsigned AW      = ptr_width(ENTRIES);
    localparam logic [AW-1:0] PtrLast = AW'(ENTRIES - 1);

    slot_state_t   state_q;
    byte_t         slot_q;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;

    logic  wr_ready, rd_valid, push, pop, arr_empty, arr_we, arr_re;
    byte_t arr_rdata;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // wr_ready uses the pre-pop level, so a full FIFO refuses a push even while popping.
    assign wr_ready  = (level_q != LW'(DEPTH));
    assign rd_valid  = (state_q == SlotFull);
    assign push      = bus.wr_valid && wr_ready;
    assign pop       = rd_valid && bus.rd_ready;
    assign arr_empty = (state_q == SlotEmpty) || (level_q == LW'(1));
    assign arr_re    = !bus.clear && pop && !arr_empty;
    // Bypass the array when the slot is empty or is being refilled straight from wr_data.
    assign arr_we    = !bus.clear && push && rd_valid && !(pop && arr_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SlotEmpty;
            slot_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else if (bus.clear) begin
            state_q    <= SlotEmpty;
            level_q    <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (bus.wr_valid && !wr_ready) overflow_q <= 1'b1;
            if (arr_we) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (arr_re) rd_ptr_q <= ptr_inc(rd_ptr_q);

            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;

            unique case (state_q)
                SlotEmpty: begin
                    if (push) begin
                        slot_q  <= bus.wr_data;
                        state_q <= SlotFull;
                    end
                end
                SlotFull: begin
                    if (pop) begin
                        if (!arr_empty) slot_q <= arr_rdata;
                        else if (push)  slot_q <= bus.wr_data;
                        else            state_q <= SlotEmpty;
                    end
                end
                default: state_q <= SlotEmpty;
            endcase
        end
    end

    serial_tx_fifo_ram #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (arr_we),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (arr_rdata)
    );

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = slot_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;

`ifdef SERIAL_TX_FIFO_LOW_WATER_IRQ_EN
    logic irq_q;

    // Compares the registered level, so irq trails a crossing by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= (level_q <= bus.threshold);
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: doc/serial_tx_fifo.md
SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: total byte capacity; power of two, minimum 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port clear, input, 1: synchronous flush.
REQ-005 SHALL have port wr_valid, input, 1: producer offers a byte.
REQ-006 SHALL have port wr_data, input, 8: byte offered.
REQ-007 SHALL have port wr_ready, output, 1: FIFO accepts a byte this cycle.
REQ-008 SHALL have port rd_valid, output, 1: byte available to the serial transmitter.
REQ-009 SHALL have port rd_data, output, 8: head byte.
REQ-010 SHALL have port rd_ready, input, 1: transmitter takes the head byte.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1: bytes held.
REQ-012 SHALL have port overflow, output, 1: sticky flag, write attempted while full.
REQ-013 SHALL have port threshold, input, $clog2(DEPTH)+1: low-water mark (only with the configuration macro).
REQ-014 SHALL have port irq, output, 1: low-water interrupt (only with the configuration macro).

Function
REQ-015 SHALL accept a push when wr_valid && wr_ready; wr_ready SHALL equal (level != DEPTH).
REQ-016 SHALL pop the head when rd_valid && rd_ready.
REQ-017 SHALL drive rd_data from a registered output slot, first-word fall-through.
REQ-018 SHALL run an output-slot FSM with two states: SLOT_EMPTY (rd_valid=0) and SLOT_FULL (rd_valid=1).
REQ-019 In SLOT_EMPTY, a push SHALL load the output slot directly, move to SLOT_FULL, and raise rd_valid the next cycle (1-cycle latency).
REQ-020 In SLOT_FULL, a pop SHALL refill the slot in the same edge from the storage array, or from wr_data if the array is empty and a push coincides. If neither source is available, the FSM SHALL go to SLOT_EMPTY.
REQ-021 The storage array SHALL hold DEPTH-1 entries, with read/write pointers wrapping modulo DEPTH-1 via explicit compare. Output slot plus array SHALL equal DEPTH.
REQ-022 On a simultaneous push and pop, level SHALL stay unchanged and byte order SHALL be preserved.
REQ-023 When full, a push with rd_ready=1 SHALL still be refused, because wr_ready is evaluated on the pre-pop level.
REQ-024 SHALL set overflow when wr_valid && !wr_ready; overflow SHALL clear only on clear or reset.
REQ-025 On clear, the next edge SHALL set level=0, set the FSM to SLOT_EMPTY, zero the pointers and clear overflow. clear SHALL take priority over a same-cycle push or pop, which are dropped.
REQ-026 level SHALL be registered and SHALL update on the same edge as the push or pop.

Reset
REQ-027 When reset_n=0, the block SHALL immediately force level=0, rd_valid=0, rd_data=0, overflow=0, irq=0, wr_ready=1, FSM=SLOT_EMPTY and pointers=0, asynchronously.
REQ-028 A reset asserted mid-transfer SHALL discard all contents. The array contents SHALL need no reset.

Configuration
REQ-029 Macro SERIAL_TX_FIFO_LOW_WATER_IRQ_EN SHALL select the low-water interrupt feature.
REQ-030 With SERIAL_TX_FIFO_LOW_WATER_IRQ_EN defined, the threshold and irq ports SHALL exist. irq SHALL be registered and SHALL be 1 exactly when the registered level is <= threshold, i.e. one cycle after the crossing edge.
REQ-031 Without SERIAL_TX_FIFO_LOW_WATER_IRQ_EN, the threshold and irq ports and their logic SHALL be absent.

Structure
REQ-032 The shared package Vermicom_pkg SHALL hold byte_t and the slot-state enum slot_state_t.
REQ-033 SHALL instantiate one sub-module, serial_tx_fifo_ram: a DEPTH-1 x 8 dual-port array with synchronous write and asynchronous read, and no reset.

Verification (bench DEPTH=4)
REQ-034 Reset release, push 0x41 at cycle 0 -> rd_valid=1, rd_data=0x41 and level=1 at cycle 1.
REQ-035 Push 0x01..0x04 with rd_ready=0 -> level=4 and wr_ready=0; a fifth push of 0x05 sets overflow=1 and is not stored; draining then yields 0x01,0x02,0x03,0x04 in that order.
REQ-036 At level=2, push 0x10 while popping every cycle for 3 cycles -> level stays 2 for the first cycle, then falls; output order is unchanged with 0x10 last.
REQ-037 Fill to 3, assert clear with a simultaneous push and pop -> next cycle level=0, rd_valid=0, overflow=0.
REQ-038 Assert reset_n=0 between clock edges at level=3 -> level=0 and rd_valid=0 before the next edge.
REQ-039 With SERIAL_TX_FIFO_LOW_WATER_IRQ_EN defined, threshold=1 and level 3 drained -> irq=0 at level 2, irq=1 one cycle after level reaches 1; pushing back to level 2 -> irq=0.
